// File: rtl/instruction_prefetch_buffer.sv
// Sequential instruction fetch stage with a credit-limited in-order {PC, instr} FIFO and redirect flush.
// Optional same-cycle response bypass to the datapath is enabled by defining PREFETCH_BYPASS_EN.
module instruction_prefetch_buffer #(
    parameter int          DEPTH         = 4,
    parameter logic [31:0] START_ADDRESS = 32'h0000_0000
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] instruction,
    output logic [31:0] ins_PC,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_PC,
    output logic        redirect_misaligned
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO    = PW'(1'b0);
    localparam logic [PW-1:0] PTR_ONE     = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO    = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1'b1);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   rsp_pc_r;
    logic [31:0]   pc_mem_r  [DEPTH];
    logic [31:0]   ins_mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] in_flight_r;
    logic [CW-1:0] drop_count_r;
    logic          misaligned_r;

    logic [CW:0]   occupancy_s;
    logic          req_valid_s;
    logic          accept_s;
    logic          rsp_ok_s;
    logic          drop_s;
    logic          keep_s;
    logic          fifo_valid_s;
    logic          bypass_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   redirect_aligned_s;

    // Buffered entries plus outstanding fetches form the credit that throttles new requests.
    assign occupancy_s        = {1'b0, count_r} + {1'b0, in_flight_r};
    assign req_valid_s        = !SYS_reset && (occupancy_s < DEPTH_LIMIT) && !redirect_valid;
    assign accept_s           = req_valid_s && mem_req_ready;
    assign rsp_ok_s           = mem_rsp_valid && (in_flight_r != CNT_ZERO);
    assign drop_s             = rsp_ok_s && (drop_count_r != CNT_ZERO);
    assign keep_s             = rsp_ok_s && !drop_s;
    assign fifo_valid_s       = (count_r != CNT_ZERO);
    assign redirect_aligned_s = {redirect_PC[31:2], 2'b00};

`ifdef PREFETCH_BYPASS_EN
    assign bypass_s = keep_s && !fifo_valid_s && !redirect_valid && !SYS_reset;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s = keep_s && !(bypass_s && ins_ready);
    assign pop_s  = fifo_valid_s && ins_ready;

    assign mem_req_valid       = req_valid_s;
    assign mem_req_addr        = fetch_pc_r;
    assign redirect_misaligned = misaligned_r;

    // Head presentation: FIFO head first, same-cycle response only when bypass is built in.
    always_comb begin
        ins_valid   = 1'b0;
        instruction = 32'h0000_0000;
        ins_PC      = 32'h0000_0000;
        if (fifo_valid_s) begin
            ins_valid   = 1'b1;
            instruction = ins_mem_r[rd_ptr_r];
            ins_PC      = pc_mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            ins_valid   = 1'b1;
            instruction = mem_rsp_data;
            ins_PC      = rsp_pc_r;
        end else begin
            ins_valid   = 1'b0;
            instruction = 32'h0000_0000;
            ins_PC      = 32'h0000_0000;
        end
    end

    // Control state: PCs, pointers, occupancy and the stale-response counter.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            fetch_pc_r   <= START_ADDRESS;
            rsp_pc_r     <= START_ADDRESS;
            rd_ptr_r     <= PTR_ZERO;
            wr_ptr_r     <= PTR_ZERO;
            count_r      <= CNT_ZERO;
            in_flight_r  <= CNT_ZERO;
            drop_count_r <= CNT_ZERO;
            misaligned_r <= 1'b0;
        end else begin
            // No request is issued during a redirect, so accept_s is already low there.
            in_flight_r <= in_flight_r + CW'(accept_s) - CW'(rsp_ok_s);
            if (redirect_valid) begin
                fetch_pc_r   <= redirect_aligned_s;
                rsp_pc_r     <= redirect_aligned_s;
                rd_ptr_r     <= PTR_ZERO;
                wr_ptr_r     <= PTR_ZERO;
                count_r      <= CNT_ZERO;
                drop_count_r <= in_flight_r - CW'(rsp_ok_s);
                if (redirect_PC[1:0] != 2'b00) begin
                    misaligned_r <= 1'b1;
                end
            end else begin
                if (accept_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
                if (drop_s) begin
                    drop_count_r <= drop_count_r - CNT_ONE;
                end
                if (keep_s) begin
                    rsp_pc_r <= rsp_pc_r + 32'd4;
                end
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                count_r <= count_r + CW'(push_s) - CW'(pop_s);
            end
        end
    end

    // FIFO storage; contents are only observable through count_r, so no reset is needed.
    always_ff @(posedge SYS_clk) begin
        if (push_s && !redirect_valid && !SYS_reset) begin
            pc_mem_r[wr_ptr_r]  <= rsp_pc_r;
            ins_mem_r[wr_ptr_r] <= mem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Bench for instruction_prefetch_buffer: in-order memory model, queue-based expected stream, directed scenarios.
module tb_instruction_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] instruction;
    logic [31:0] ins_PC;
    logic        redirect_valid;
    logic [31:0] redirect_PC;
    logic        redirect_misaligned;

    always #5 SYS_clk = ~SYS_clk;

    instruction_prefetch_buffer #(.DEPTH(DEPTH), .START_ADDRESS(32'h0000_0000)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .instruction(instruction), .ins_PC(ins_PC),
        .redirect_valid(redirect_valid), .redirect_PC(redirect_PC),
        .redirect_misaligned(redirect_misaligned)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    int          stale = 0;
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] exp_rsp_pc = 32'h0;
    logic        exp_mis = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are compared against the model, model advances.
    task automatic tick();
        logic        rsp;
        logic        exp_req;
        logic        exp_iv;
        logic [31:0] head;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'hDEAD_BEEF;
        end
        @(negedge SYS_clk);
        assert (!mem_rsp_valid || mem_q.size() > 0);
        exp_req = !redirect_valid && ((exp_q.size() + mem_q.size()) < DEPTH);
        exp_iv  = (exp_q.size() > 0);
        head    = exp_iv ? exp_q[0] : 32'h0;
        chk1("mem_req_valid", mem_req_valid, exp_req);
        if (exp_req) chk("mem_req_addr", mem_req_addr, exp_fetch);
        chk1("ins_valid", ins_valid, exp_iv);
        chk("ins_PC", ins_PC, head);
        chk("instruction", instruction, exp_iv ? mem_word(head) : 32'h0);
        chk1("redirect_misaligned", redirect_misaligned, exp_mis);
        rsp = mem_rsp_valid;
        if (redirect_valid) begin
            stale = mem_q.size() - (rsp ? 1 : 0);
            exp_q.delete();
            exp_fetch  = {redirect_PC[31:2], 2'b00};
            exp_rsp_pc = exp_fetch;
            if (redirect_PC[1:0] != 2'b00) exp_mis = 1'b1;
        end else begin
            if (exp_iv && ins_ready) void'(exp_q.pop_front());
            if (rsp) begin
                if (stale > 0) stale--;
                else begin
                    exp_q.push_back(exp_rsp_pc);
                    exp_rsp_pc = exp_rsp_pc + 32'd4;
                end
            end
            if (exp_req && mem_req_ready) exp_fetch = exp_fetch + 32'd4;
        end
        if (rsp) void'(mem_q.pop_front());
        if (mem_req_valid && mem_req_ready) begin
            mem_q.push_back('{mem_req_addr, cyc + lat});
            acc_cnt++;
        end
        @(posedge SYS_clk);
        #2;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        SYS_reset      = 1'b1;
        redirect_valid = 1'b0;
        redirect_PC    = 32'h0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        mem_q.delete();
        exp_q.delete();
        stale      = 0;
        exp_fetch  = 32'h0;
        exp_rsp_pc = 32'h0;
        exp_mis    = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk1("rst_req_valid", mem_req_valid, 1'b0);
            chk1("rst_ins_valid", ins_valid, 1'b0);
            chk("rst_instruction", instruction, 32'h0);
            chk1("rst_misaligned", redirect_misaligned, 1'b0);
            @(posedge SYS_clk);
            #2;
            cyc++;
        end
        SYS_reset = 1'b0;
    endtask

    task automatic wait_first_ins(input string name, input logic [31:0] pc, input logic [31:0] data);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #1;
            if (ins_valid) begin
                found = 1'b1;
                chk({name, "_pc"}, ins_PC, pc);
                chk({name, "_data"}, instruction, data);
            end
            tick();
        end
        chk1({name, "_seen"}, found, 1'b1);
    endtask

    initial begin
        logic        saw_wrap;
        logic        prev_v;
        logic [31:0] prev_pc;
        SYS_reset = 1'b1; mem_req_ready = 1'b0; ins_ready = 1'b0;
        redirect_valid = 1'b0; redirect_PC = 32'h0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        @(posedge SYS_clk);
        #2;

        // Startup with 1-cycle memory: two-cycle latency then one instruction per cycle.
        lat = 1; mem_req_ready = 1'b1; ins_ready = 1'b1;
        do_reset(2);
        #1;
        chk1("t1_req_valid0", mem_req_valid, 1'b1);
        chk("t1_addr0", mem_req_addr, 32'h0000_0000);
        chk1("t1_iv0", ins_valid, 1'b0);
        tick(); #1;
        chk("t1_addr1", mem_req_addr, 32'h0000_0004);
        chk1("t1_iv1", ins_valid, 1'b0);
        tick(); #1;
        chk1("t1_iv2", ins_valid, 1'b1);
        chk("t1_pc2", ins_PC, 32'h0000_0000);
        chk("t1_data2", instruction, 32'h1234_5678);
        tick(); #1;
        chk("t1_pc3", ins_PC, 32'h0000_0004);
        chk("t1_data3", instruction, 32'h6AE9_B0BC);
        repeat (8) tick();

        // Back-pressure: exactly DEPTH requests, then one refill per pop.
        lat = 1; ins_ready = 1'b0;
        do_reset(1);
        acc_cnt = 0;
        repeat (10) tick();
        #1;
        chk("t2_accepts", 32'(acc_cnt), 32'd4);
        chk1("t2_req_stalled", mem_req_valid, 1'b0);
        chk1("t2_full_valid", ins_valid, 1'b1);
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        #1;
        chk1("t2_refill", mem_req_valid, 1'b1);
        tick(); #1;
        chk("t2_accepts2", 32'(acc_cnt), 32'd5);
        chk1("t2_stall2", mem_req_valid, 1'b0);
        repeat (3) tick();
        ins_ready = 1'b1;
        repeat (6) tick();

        // 3-cycle memory, two stale fetches dropped after redirect to 0x100.
        lat = 3; ins_ready = 1'b0; mem_req_ready = 1'b1;
        do_reset(1);
        tick(); tick();
        redirect_valid = 1'b1; redirect_PC = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0; ins_ready = 1'b1;
        #1;
        chk1("t3_flushed", ins_valid, 1'b0);
        wait_first_ins("t3_first", 32'h0000_0100, 32'h254D_E778);
        repeat (4) tick();

        // Redirect coinciding with a response and a pop.
        lat = 2; ins_ready = 1'b1; mem_req_ready = 1'b1;
        do_reset(1);
        repeat (6) tick();
        #1;
        chk1("t4_pre_valid", ins_valid, 1'b1);
        redirect_valid = 1'b1; redirect_PC = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        wait_first_ins("t4_first", 32'h0000_0400, 32'hCFD2_9278);
        repeat (4) tick();

        // Misaligned redirect: aligned restart, sticky flag.
        lat = 1;
        redirect_valid = 1'b1; redirect_PC = 32'h0000_0202;
        tick();
        redirect_valid = 1'b0;
        wait_first_ins("t5_first", 32'h0000_0200, 32'h7CC7_3478);
        #1;
        chk1("t5_mis_set", redirect_misaligned, 1'b1);
        redirect_valid = 1'b1; redirect_PC = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        repeat (4) tick();
        #1;
        chk1("t5_mis_sticky", redirect_misaligned, 1'b1);

        // Address wrap at the top of the 32-bit space.
        redirect_valid = 1'b1; redirect_PC = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        saw_wrap = 1'b0; prev_v = 1'b0; prev_pc = 32'h0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (ins_valid) begin
                if (prev_v && prev_pc == 32'hFFFF_FFFC) begin
                    saw_wrap = 1'b1;
                    chk("t6_wrap_pc", ins_PC, 32'h0000_0000);
                end
                prev_pc = ins_PC;
            end
            prev_v = ins_valid;
            tick();
        end
        chk1("t6_wrap_seen", saw_wrap, 1'b1);

        // Back-to-back redirects under irregular handshakes; reset clears the sticky flag.
        lat = 3;
        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            ins_ready      = (i % 3 != 0);
            mem_req_ready  = (i % 4 != 1);
            redirect_valid = (i == 10 || i == 11);
            redirect_PC    = (i == 10) ? 32'h0000_0500 : 32'h0000_0600;
            tick();
        end
        redirect_valid = 1'b0; ins_ready = 1'b1; mem_req_ready = 1'b1;
        repeat (15) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
